// File: rtl/matrix_result_buffer.sv
// Result stage for the matrix multiplier. It narrows each wide element by truncation or saturation
// and queues the results in a first-word-fall-through FIFO with a registered head.
module matrix_result_buffer #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       sat_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       clipped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [OUT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    rptr_next;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    remaining;
  logic [OUT_W-1:0] head_q;
  logic             clipped_q;
  logic [OUT_W-1:0] conv;
  logic             lossy;
  logic             push;
  logic             pop;

  logic [IN_W-OUT_W-1:0] upper;
  logic [IN_W-OUT_W:0]   sign_ext;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign out_data  = head_q;
  assign count     = count_q;
  assign clipped   = clipped_q;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign rptr_next = rptr + PW'(1);
  assign remaining = count_q - CW'(pop);

  assign upper    = in_data[IN_W-1:OUT_W];
  assign sign_ext = in_data[IN_W-1:OUT_W-1];

  // Narrowing is done at write time, so a later sat_mode change never touches stored entries.
  always_comb begin
    conv  = in_data[OUT_W-1:0];
    lossy = 1'b0;
    if (SIGNED != 0) begin
      lossy = !((&sign_ext) || !(|sign_ext));
      if (sat_mode && lossy) begin
        conv = {in_data[IN_W-1], {(OUT_W-1){~in_data[IN_W-1]}}};
      end
    end else begin
      lossy = |upper;
      if (sat_mode && lossy) begin
        conv = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear && !reset) begin
      mem[wptr] <= conv;
    end
  end

  // The head register is reloaded whenever the current head leaves or the FIFO is empty.
  // It takes the next stored entry, or the incoming element when nothing else remains,
  // which gives first-word-fall-through with no read bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count_q   <= '0;
      clipped_q <= 1'b0;
      head_q    <= '0;
    end else if (clear) begin
      wptr      <= '0;
      rptr      <= '0;
      count_q   <= '0;
      clipped_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr_next;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push && lossy) begin
        clipped_q <= 1'b1;
      end
      if (pop || (count_q == '0)) begin
        if (remaining != '0) begin
          head_q <= mem[pop ? rptr_next : rptr];
        end else if (push) begin
          head_q <= conv;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_result_buffer.sv
// Directed bench for matrix_result_buffer: an unsigned instance driven against a queue scoreboard,
// and a signed instance for the saturating conversion cases.
module tb_matrix_result_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear, sat_mode, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, clipped;
  logic [7:0]  out_data;
  logic [4:0]  count;

  logic        s_clear, s_sat_mode, s_in_valid, s_out_ready;
  logic [31:0] s_in_data;
  logic        s_in_ready, s_out_valid, s_clipped;
  logic [7:0]  s_out_data;
  logic [4:0]  s_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  sb[$];
  int          mc = 0;
  bit          mclip = 1'b0;

  always #5 clk = ~clk;

  matrix_result_buffer #(.IN_W(32), .OUT_W(8), .DEPTH(16), .SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .sat_mode(sat_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .clipped(clipped)
  );

  matrix_result_buffer #(.IN_W(32), .OUT_W(8), .DEPTH(16), .SIGNED(1)) u_sdut (
    .clk(clk), .reset(reset), .clear(s_clear), .sat_mode(s_sat_mode),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .count(s_count), .clipped(s_clipped)
  );

  function automatic bit ulossy(logic [31:0] d);
    return d > 32'd255;
  endfunction

  function automatic logic [7:0] uconv(logic [31:0] d, bit sat);
    logic [7:0] lo;
    lo = d[7:0];
    return (sat && d > 32'd255) ? 8'hFF : lo;
  endfunction

  function automatic bit slossy(logic [31:0] d);
    int s;
    s = $signed(d);
    return (s > 127) || (s < -128);
  endfunction

  function automatic logic [7:0] sconv(logic [31:0] d, bit sat);
    int s;
    logic [7:0] lo;
    s  = $signed(d);
    lo = d[7:0];
    if (sat && s > 127) return 8'h7F;
    if (sat && s < -128) return 8'h80;
    return lo;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the unsigned instance; the model decides push/pop from its own occupancy.
  task automatic cycle(bit v, logic [31:0] d, bit sat, bit rdy);
    bit p, q;
    logic [7:0] e;
    p = v && (mc != 16);
    q = rdy && (mc != 0);
    in_valid  = v;
    in_data   = d;
    sat_mode  = sat;
    out_ready = rdy;
    if (q) begin
      e = sb.pop_front();
      check("pop_data", {24'd0, out_data}, {24'd0, e});
    end
    if (p) begin
      sb.push_back(uconv(d, sat));
      if (ulossy(d)) mclip = 1'b1;
    end
    mc = mc + int'(p) - int'(q);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("count", {27'd0, count}, mc);
    check("clipped", {31'd0, clipped}, {31'd0, mclip});
    check("out_valid", {31'd0, out_valid}, {31'd0, mc != 0});
    check("in_ready", {31'd0, in_ready}, {31'd0, mc != 16});
  endtask

  task automatic do_clear(bit v, logic [31:0] d);
    clear    = 1'b1;
    in_valid = v;
    in_data  = d;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    mc    = 0;
    mclip = 1'b0;
    check("clr_count", {27'd0, count}, 32'd0);
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    check("clr_clipped", {31'd0, clipped}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; sat_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    s_clear = 1'b0; s_sat_mode = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_clipped", {31'd0, clipped}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);

    // Unsigned truncate then saturate of the same element
    cycle(1'b1, 32'h0000_01A5, 1'b0, 1'b0);
    check("trunc_head", {24'd0, out_data}, 32'hA5);
    cycle(1'b1, 32'h0000_01A5, 1'b1, 1'b0);
    check("sat_entry", {24'd0, sb[1]}, 32'hFF);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);

    // Signed saturation on the second instance
    s_in_valid = 1'b1; s_in_data = 32'hFFFF_FF38;
    tick();
    check("s_head_m200", {24'd0, s_out_data}, {24'd0, sconv(32'hFFFF_FF38, 1'b1)});
    check("s_clipped_m200", {31'd0, s_clipped}, {31'd0, slossy(32'hFFFF_FF38)});
    s_in_data = 32'hFFFF_FFF6;
    tick();
    s_in_valid = 1'b0;
    check("s_count", {27'd0, s_count}, 32'd2);
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
    check("s_head_m10", {24'd0, s_out_data}, {24'd0, sconv(32'hFFFF_FFF6, 1'b1)});
    check("s_clipped_hold", {31'd0, s_clipped}, 32'd1);

    // Fill to full, then a push blocked even with a same-cycle pop, then drain in order
    do_clear(1'b0, 32'd0);
    for (int i = 0; i < 16; i++) cycle(1'b1, i, 1'b0, 1'b0);
    cycle(1'b1, 32'd99, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    check("empty_hold", {24'd0, out_data}, 32'd15);

    // Steady streaming at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'd100 + i, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'd200 + i, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);

    // Clear mid-stream with a same-cycle push
    cycle(1'b1, 32'h0000_01FF, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'd10 + i, 1'b1, 1'b0);
    do_clear(1'b1, 32'h0000_0077);
    cycle(1'b1, 32'h0000_0042, 1'b0, 1'b0);
    check("post_clear_head", {24'd0, out_data}, 32'h42);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
